quant_coef_pipe: RTL and testbench

//   Streaming quantiser stage that drives the constant multiplier in the compression

---
 rtl/quant_coef_pipe.sv | 125 ++++++++++++
 tb/tb_quant_coef_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_coef_pipe.sv
// quant_coef_pipe
//   Two-stage streaming quantiser. Each signed coefficient is multiplied by an
//   unsigned reciprocal constant chosen by its position in the block. The product
//   is rounded half toward +inf, shifted down by FRAC and saturated to OUT_W bits.
//   Results leave tagged with their block position.
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    coefficient input stream
//   q_we/q_addr/q_data           quant-table write port (one entry per position)
//   out_valid/out_ready          output stream handshake
//   out_data/out_idx/out_last    quantised value, block position, last-in-block flag
//   out_sat                      out_data was clipped
module quant_coef_pipe #(
    parameter int IN_W    = 32,
    parameter int CONST_W = 16,
    parameter int FRAC    = 15,
    parameter int OUT_W   = 16,
    parameter int N_COEF  = 64,
    localparam int IDX_W  = $clog2(N_COEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               q_we,
    input  logic [IDX_W-1:0]   q_addr,
    input  logic [CONST_W-1:0] q_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               out_sat
);

    localparam int PROD_W = IN_W + CONST_W + 1;
    localparam logic [CONST_W-1:0]       ONE_Q    = CONST_W'(2**FRAC);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_COEF - 1);
    localparam logic signed [PROD_W-1:0] ROUND    = PROD_W'(2**(FRAC-1));
    localparam logic signed [PROD_W-1:0] SAT_HI   = PROD_W'(2**(OUT_W-1) - 1);
    // ~x == -x-1, so this is -2^(OUT_W-1)
    localparam logic signed [PROD_W-1:0] SAT_LO   = ~SAT_HI;
    localparam logic [OUT_W-1:0]         OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]         OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    logic                      stall;
    logic                      accept;
    logic [IDX_W-1:0]          cnt;
    logic [CONST_W-1:0]        q_tab [N_COEF];

    logic                      s1_valid;
    logic [IDX_W-1:0]          s1_idx;
    logic signed [PROD_W-1:0]  s1_prod;

    logic signed [PROD_W-1:0]  mul_a;
    logic signed [PROD_W-1:0]  mul_b;
    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  r_sum;
    logic signed [PROD_W-1:0]  r_shift;

    assign stall    = out_valid && !out_ready;
    assign in_ready = rst ? 1'b0 : !stall;
    assign accept   = in_valid && in_ready;

    // Operands widened to the full product width so the multiply is exact;
    // the constant is zero-extended because it is unsigned.
    always_comb begin
        mul_a   = {{(PROD_W-IN_W){in_data[IN_W-1]}}, in_data};
        mul_b   = {{(PROD_W-CONST_W){1'b0}}, q_tab[cnt]};
        prod    = mul_a * mul_b;
        r_sum   = s1_prod + ROUND;
        r_shift = r_sum >>> FRAC;
    end

    // Table is written independently of the stall. A same-edge accept reads the
    // pre-write entry because the read is combinational from the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_COEF; i++) begin
                q_tab[i] <= ONE_Q;
            end
        end else if (q_we) begin
            q_tab[q_addr] <= q_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_prod   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= prod;
                s1_idx  <= cnt;
                cnt     <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
            end

            out_valid <= s1_valid;
            if (s1_valid) begin
                out_idx  <= s1_idx;
                out_last <= (s1_idx == LAST_IDX);
                if (r_shift > SAT_HI) begin
                    out_data <= OUT_MAX;
                    out_sat  <= 1'b1;
                end else if (r_shift < SAT_LO) begin
                    out_data <= OUT_MIN;
                    out_sat  <= 1'b1;
                end else begin
                    out_data <= r_shift[OUT_W-1:0];
                    out_sat  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_quant_coef_pipe.sv
// tb_quant_coef_pipe
//   Directed bench for quant_coef_pipe. Expected outputs come from a behavioural
//   model of the table, position counter and rounding/saturation, pushed to a
//   scoreboard queue on each accepted input and compared whenever out_valid is high.
module tb_quant_coef_pipe;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  idx;
        logic        last;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        q_we;
    logic [5:0]  q_addr;
    logic [15:0] q_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        out_sat;

    exp_t        sb[$];
    logic [15:0] qm [64];
    logic [5:0]  model_cnt;
    logic        last_acc;
    logic        last_inr;
    logic [15:0] last_pop_data;
    logic [5:0]  last_pop_idx;
    logic        last_pop_sat;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    quant_coef_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .q_we      (q_we),
        .q_addr    (q_addr),
        .q_data    (q_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] d, input logic [15:0] q, input logic [5:0] idx);
        longint p;
        longint r;
        exp_t   e;
        p = longint'($signed(d)) * longint'({48'd0, q});
        r = (p + 64'sd16384) >>> 15;
        if (r > 32767) begin
            e.data = 16'h7FFF;
            e.sat  = 1'b1;
        end else if (r < -32768) begin
            e.data = 16'h8000;
            e.sat  = 1'b1;
        end else begin
            e.data = r[15:0];
            e.sat  = 1'b0;
        end
        e.idx  = idx;
        e.last = (idx == 6'd63);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) qm[i] = 16'h8000;
        model_cnt = '0;
        sb.delete();
    endtask

    // One clock: snapshot handshakes just after the falling edge, check output
    // against the scoreboard head, update the model, then advance one cycle.
    task automatic cyc();
        exp_t e;
        #1;
        if (out_valid === 1'b1) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL spurious_out observed=out_valid_with_empty_scoreboard expected=no_output idx=%0d", out_idx);
            end
            if (sb.size() > 0) begin
                e = sb[0];
                chk("out_data", 64'(out_data), 64'(e.data));
                chk("out_idx",  64'(out_idx),  64'(e.idx));
                chk("out_last", 64'(out_last), 64'(e.last));
                chk("out_sat",  64'(out_sat),  64'(e.sat));
                if (out_ready) begin
                    last_pop_data = out_data;
                    last_pop_idx  = out_idx;
                    last_pop_sat  = out_sat;
                    void'(sb.pop_front());
                end
            end
            if (!out_ready) chk("in_ready_stall", 64'(in_ready), 64'd0);
        end
        last_inr = in_ready;
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            sb.push_back(model(in_data, qm[model_cnt], model_cnt));
            model_cnt = model_cnt + 6'd1;
        end
        if (q_we && !rst) qm[q_addr] = q_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!last_acc && k < 20);
        chk("send_accepted", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic fill_to(input logic [5:0] target);
        int k;
        k = 0;
        while (model_cnt != target && k < 200) begin
            in_valid = 1'b1;
            in_data  = 32'(int'($urandom_range(0, 4000)) - 2000);
            cyc();
            k++;
        end
        in_valid = 1'b0;
        chk("fill_to_reached", 64'(model_cnt), 64'(target));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 20) begin
            cyc();
            k++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int c;
        int i;
        int n_stall;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        q_we      = 1'b0;
        q_addr    = '0;
        q_data    = '0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_idx",   64'(out_idx),   64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_sat",   64'(out_sat),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // 1: unity table, two-cycle latency
        send(32'd1000);
        #1;
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        cyc();
        #1;
        chk("lat_two", 64'(out_valid), 64'd1);
        drain();
        chk("t1_data", 64'(last_pop_data), 64'd1000);
        chk("t1_idx",  64'(last_pop_idx),  64'd0);
        chk("t1_sat",  64'(last_pop_sat),  64'd0);

        // 2/3: half constant and near-2.0 constant with saturation
        q_we = 1'b1; q_addr = 6'd1; q_data = 16'h4000;
        cyc();
        q_we = 1'b1; q_addr = 6'd2; q_data = 16'hFFFF;
        cyc();
        q_we = 1'b0;
        send(32'd3);
        drain();
        chk("t2_pos_half", 64'(last_pop_data), 64'd2);
        send(32'd30000);
        drain();
        chk("t3_sat_hi", 64'(last_pop_data), 64'h7FFF);
        chk("t3_sat_hi_flag", 64'(last_pop_sat), 64'd1);
        fill_to(6'd1);
        send(-32'sd3);
        drain();
        chk("t2_neg_half", 64'(last_pop_data), 64'hFFFF);
        send(-32'sd30000);
        drain();
        chk("t3_sat_lo", 64'(last_pop_data), 64'h8000);
        chk("t3_sat_lo_flag", 64'(last_pop_sat), 64'd1);

        // 4: full block back-to-back with a 5-cycle downstream stall and a
        //    table write landing during the stall
        fill_to(6'd0);
        drain();
        c = 0; i = 0; n_stall = 0;
        while (i < 64 && c < 200) begin
            out_ready = !(c >= 5 && c <= 9);
            q_we      = (c == 7);
            q_addr    = 6'd40;
            q_data    = 16'h4000;
            in_valid  = 1'b1;
            in_data   = 32'(i * 997 - 31000);
            cyc();
            if (c >= 5 && c <= 9 && !last_inr) n_stall++;
            if (last_acc) i++;
            c++;
        end
        in_valid  = 1'b0;
        q_we      = 1'b0;
        out_ready = 1'b1;
        chk("t4_all_accepted", 64'(i), 64'd64);
        chk("t4_stall_cycles", 64'(n_stall), 64'd5);
        drain();
        chk("t4_last_idx", 64'(last_pop_idx), 64'd63);
        send(32'd77);
        drain();
        chk("t4_wrap_idx", 64'(last_pop_idx), 64'd0);

        // 5: write and accept to the same position on the same edge
        fill_to(6'd5);
        q_we = 1'b1; q_addr = 6'd5; q_data = 16'h2000;
        send(32'd1000);
        q_we = 1'b0;
        drain();
        chk("t5_old_const", 64'(last_pop_data), 64'd1000);
        fill_to(6'd5);
        send(32'd1000);
        drain();
        chk("t5_new_const", 64'(last_pop_data), 64'd250);

        // 6: reset mid-block discards in-flight samples and restores the table
        q_we = 1'b1; q_addr = 6'd0; q_data = 16'h4000;
        cyc();
        q_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k * 100);
            cyc();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_in_ready",  64'(in_ready),  64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(32'd1000);
        drain();
        chk("t6_idx_restart", 64'(last_pop_idx),  64'd0);
        chk("t6_unity_const", 64'(last_pop_data), 64'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
